seq_gen: RTL and testbench

SEQ_GEN -- requirements
Module: seq_gen

---
 rtl/seq_gen_pkg.sv | 13 +
 rtl/seq_track.sv | 45 ++++
 rtl/seq_gen.sv | 102 ++++++++++
 tb/tb_seq_gen.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// Shared types and sizing constants for the serial frame generator.
package seq_gen_pkg;

   localparam int unsigned MAX_LEN_DEF = 16;
   localparam int unsigned LEN_W       = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage : seq_gen_pkg

// File: rtl/seq_track.sv
// Running predictor of the recognizer output: saturating ones count and zero parity.
module seq_track (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   input  logic bit_in,
   output logic f
);

   logic [1:0] r_ones;
   logic       r_par;
   logic       r_f;
   logic [1:0] w_ones_nxt;
   logic       w_par_nxt;

   // Next tracker values for the bit currently on the wire.
   always_comb begin
      w_ones_nxt = r_ones;
      w_par_nxt  = r_par ^ ~bit_in;
      if (bit_in && (r_ones != 2'd2)) begin
         w_ones_nxt = r_ones + 2'd1;
      end
   end

   // Trackers and the registered prediction; only transmitted bits count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ones <= 2'd0;
         r_par  <= 1'b0;
         r_f    <= 1'b0;
      end else if (clr) begin
         r_ones <= 2'd0;
         r_par  <= 1'b0;
         r_f    <= 1'b0;
      end else if (en) begin
         r_ones <= w_ones_nxt;
         r_par  <= w_par_nxt;
         r_f    <= (w_ones_nxt == 2'd2) && w_par_nxt;
      end
   end

   assign f = r_f;

endmodule : seq_track

// File: rtl/seq_gen.sv
// Serial frame generator: shifts a captured pattern out MSB-first with sink stall.
module seq_gen
   import seq_gen_pkg::*;
#(
   parameter int unsigned MAX_LEN = MAX_LEN_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [LEN_W-1:0]   len,
   input  logic               hold,
   output logic               x,
   output logic               x_valid,
   output logic               busy,
   output logic               done,
   output logic               expect_f
);

   localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [MAX_LEN-1:0] r_pat;
   logic [IDX_W-1:0]   r_idx;
   logic [IDX_W-1:0]   w_idx_nxt;
   logic [LEN_W-1:0]   w_len_eff;
   logic               w_clr;
   logic               w_x;
   logic               w_x_valid;
   logic               w_f;

   // Oversized lengths are clamped to the pattern width.
   assign w_len_eff = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;

   // Next-state, bit index and tracker control.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_clr       = 1'b0;
      w_x         = 1'b0;
      w_x_valid   = 1'b0;
      case (r_state)
         IDLE: begin
            if (start && (len != '0)) begin
               w_clr       = 1'b1;
               w_idx_nxt   = IDX_W'(w_len_eff - LEN_W'(1));
               w_state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            w_x = r_pat[r_idx];
            if (!hold) begin
               w_x_valid = 1'b1;
               if (r_idx == '0) begin
                  w_state_nxt = DONE;
               end else begin
                  w_idx_nxt = r_idx - IDX_W'(1);
               end
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State, captured frame and bit index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_pat   <= '0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         if (w_clr) begin
            r_pat <= pattern;
         end
      end
   end

   seq_track u_track (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (w_clr),
      .en     (w_x_valid),
      .bit_in (w_x),
      .f      (w_f)
   );

   // x/x_valid follow hold in the same cycle so a stall costs no extra latency.
   assign x        = w_x;
   assign x_valid  = w_x_valid;
   assign busy     = (r_state != IDLE);
   assign done     = (r_state == DONE);
   assign expect_f = w_f;

endmodule : seq_gen

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen with hand-computed frame traces.
module tb_seq_gen;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] pattern;
   logic [4:0]  len;
   logic        hold;
   logic        x;
   logic        x_valid;
   logic        busy;
   logic        done;
   logic        expect_f;

   int          n_cmp;
   int          n_err;

   logic [31:0] got_bits;
   logic [31:0] vtrace;
   logic [31:0] eftrace;
   int          nbits;
   int          busy_cyc;
   int          done_cnt;
   logic [1:0]  idle_xv;
   logic        ef_final;
   logic        timeout;
   logic        any_busy;
   logic        any_v;

   seq_gen #(.MAX_LEN(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .pattern  (pattern),
      .len      (len),
      .hold     (hold),
      .x        (x),
      .x_valid  (x_valid),
      .busy     (busy),
      .done     (done),
      .expect_f (expect_f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts and reports a mismatch.
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Request one frame, then record per-cycle outputs until busy drops.
   task automatic run_frame(input logic [15:0] pat, input logic [4:0] ln,
                            input logic [31:0] hmask, input logic keep_start);
      got_bits = '0; vtrace = '0; eftrace = '0;
      nbits = 0; busy_cyc = 0; done_cnt = 0; timeout = 1'b1;
      idle_xv = 2'b11; ef_final = 1'bx;
      @(negedge clk);
      start = 1'b1; pattern = pat; len = ln; hold = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         start = keep_start;
         hold  = hmask[c];
         #1;
         if (!busy) begin
            idle_xv  = {x, x_valid};
            ef_final = expect_f;
            timeout  = 1'b0;
            break;
         end
         busy_cyc++;
         eftrace = {eftrace[30:0], expect_f};
         if (done) done_cnt++;
         else      vtrace = {vtrace[30:0], x_valid};
         if (x_valid) begin
            got_bits = {got_bits[30:0], x};
            nbits++;
         end
      end
      hold = 1'b0;
      chk("frame_timeout", 32'(timeout), 32'd0);
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      rst_n = 1'b0; start = 1'b0; pattern = '0; len = '0; hold = 1'b0;
      #1;
      chk("reset_outs", {27'd0, x, x_valid, busy, done, expect_f}, 32'd0);
      #20;
      @(negedge clk);
      rst_n = 1'b1;

      // 110, len 3
      run_frame(16'b110, 5'd3, 32'd0, 1'b0);
      chk("f110_bits", got_bits, 32'b110);
      chk("f110_nbits", 32'(nbits), 32'd3);
      chk("f110_valid", vtrace, 32'b111);
      chk("f110_ef", eftrace, 32'b0001);
      chk("f110_busy", 32'(busy_cyc), 32'd4);
      chk("f110_done", 32'(done_cnt), 32'd1);
      chk("f110_idle_xv", 32'(idle_xv), 32'd0);
      repeat (2) @(negedge clk);
      #1;
      chk("f110_ef_hold", 32'(expect_f), 32'd1);

      // 1100, len 4: prediction rises after bit 3 and falls after bit 4
      run_frame(16'b1100, 5'd4, 32'd0, 1'b0);
      chk("f1100_bits", got_bits, 32'b1100);
      chk("f1100_ef", eftrace, 32'b00010);
      chk("f1100_ef_final", 32'(ef_final), 32'd0);

      // 101 with two stall cycles after bit 1
      run_frame(16'b101, 5'd3, 32'h6, 1'b0);
      chk("hold_valid", vtrace, 32'b10011);
      chk("hold_bits", got_bits, 32'b101);
      chk("hold_busy", 32'(busy_cyc), 32'd6);
      chk("hold_ef", eftrace, 32'b000001);

      // len 0 request is ignored
      any_busy = 1'b0; any_v = 1'b0;
      @(negedge clk);
      start = 1'b1; len = 5'd0; pattern = 16'hFFFF;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1;
         any_busy |= busy;
         any_v    |= x_valid;
      end
      start = 1'b0;
      chk("len0_busy", 32'(any_busy), 32'd0);
      chk("len0_valid", 32'(any_v), 32'd0);

      // len 20 clamps to 16
      run_frame(16'hA5C3, 5'd20, 32'd0, 1'b0);
      chk("len20_nbits", 32'(nbits), 32'd16);
      chk("len20_bits", got_bits, 32'h0000A5C3);
      chk("len20_busy", 32'(busy_cyc), 32'd17);

      // Reset after bit 2 of a 5-bit frame
      @(negedge clk);
      start = 1'b1; pattern = 16'b10110; len = 5'd5;
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("rst_bit1", {30'd0, x, x_valid}, 32'b11);
      @(negedge clk);
      #1;
      chk("rst_bit2", {30'd0, x, x_valid}, 32'b01);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_outs", {27'd0, x, x_valid, busy, done, expect_f}, 32'd0);
      @(negedge clk);
      #1;
      chk("rst_no_done", {30'd0, busy, done}, 32'd0);
      rst_n = 1'b1;
      run_frame(16'b10110, 5'd5, 32'd0, 1'b0);
      chk("post_rst_bits", got_bits, 32'b10110);
      chk("post_rst_done", 32'(done_cnt), 32'd1);
      chk("post_rst_busy", 32'(busy_cyc), 32'd6);

      // start held high throughout: no mid-frame restart
      run_frame(16'b101, 5'd3, 32'd0, 1'b1);
      chk("hold_start_bits", got_bits, 32'b101);
      chk("hold_start_busy", 32'(busy_cyc), 32'd4);
      chk("hold_start_done", 32'(done_cnt), 32'd1);
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("restart_from_idle", 32'(busy), 32'd1);
      timeout = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         #1;
         if (!busy) begin
            timeout = 1'b0;
            break;
         end
      end
      chk("restart_finish", 32'(timeout), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_seq_gen
